// File: rtl/bsg_link_oddr_upstream.sv
// bsg_link_oddr_upstream
//   Transmit-side framing and credit stage feeding the ODDR PHY. Buffers a
//   valid/ready payload stream in a 2-entry FIFO, frames each payload into a
//   2x-channel-wide PHY word with a valid bit at the top of each half, and
//   only issues words while receiver credits remain. After reset a fixed
//   idle preamble is delivered before the link goes active.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   INIT   | send idle words until init_idle_words_p have been taken
//   ACTIVE | send framed FIFO head whenever FIFO non-empty and credit > 0
//
// Ports
//   clk_i             core clock (shared with the PHY)
//   reset_i           asynchronous active-high reset
//   data_i / v_i      payload and its valid
//   ready_o           registered payload accept (FIFO not full)
//   phy_data_o        word to the PHY, {v, hi half, v, lo half}
//   phy_ready_i       PHY captures phy_data_o on a posedge where this is 1
//   token_i           credit-return pulse, worth token_decimation_p credits
//   link_active_o     high once the preamble is complete
//   credit_overflow_o sticky: credit count would have exceeded credits_p
//   credits_o         current credit count
module bsg_link_oddr_upstream #(
  parameter int channel_width_p    = 16,
  parameter int credits_p          = 16,
  parameter int token_decimation_p = 4,
  parameter int init_idle_words_p  = 8,
  localparam int payload_width_p   = 2*(channel_width_p-1),
  localparam int credit_width_lp   = $clog2(credits_p+1)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [payload_width_p-1:0]   data_i,
  input  logic                         v_i,
  output logic                         ready_o,
  output logic [2*channel_width_p-1:0] phy_data_o,
  input  logic                         phy_ready_i,
  input  logic                         token_i,
  output logic                         link_active_o,
  output logic                         credit_overflow_o,
  output logic [credit_width_lp-1:0]   credits_o
);

  localparam int half_lp           = payload_width_p/2;
  localparam int idle_cnt_width_lp = (init_idle_words_p > 1) ? $clog2(init_idle_words_p) : 1;
  // wide enough to hold credits_p + one token's worth before saturation
  localparam int sum_width_lp      = $clog2(credits_p+token_decimation_p+1);

  typedef enum logic {INIT, ACTIVE} state_e;

  state_e                       state_r;
  logic [idle_cnt_width_lp-1:0] idle_cnt_r;

  logic [payload_width_p-1:0]   mem_r [2];
  logic                         wr_ptr_r, rd_ptr_r;
  logic [1:0]                   count_r, count_n;
  logic                         ready_r;

  logic [credit_width_lp-1:0]   credits_r;
  logic                         overflow_r;
  logic [sum_width_lp-1:0]      credit_sum;

  logic                         enq, deq, eligible, send;
  logic [payload_width_p-1:0]   head;

  assign head     = mem_r[rd_ptr_r];
  assign eligible = (state_r == ACTIVE) && (count_r != 2'd0) && (credits_r != '0);
  assign send     = eligible && phy_ready_i;
  assign enq      = v_i && ready_r;
  assign deq      = send;

  always_comb begin
    count_n = count_r;
    if (enq && !deq)
      count_n = count_r + 2'd1;
    else if (!enq && deq)
      count_n = count_r - 2'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
      ready_r  <= 1'b1;
    end else begin
      if (enq) begin
        mem_r[wr_ptr_r] <= data_i;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (deq)
        rd_ptr_r <= ~rd_ptr_r;
      count_r <= count_n;
      ready_r <= (count_n != 2'd2);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r    <= INIT;
      idle_cnt_r <= '0;
    end else begin
      case (state_r)
        INIT: begin
          if (phy_ready_i) begin
            if (idle_cnt_r == idle_cnt_width_lp'(init_idle_words_p-1))
              state_r <= ACTIVE;
            else
              idle_cnt_r <= idle_cnt_r + idle_cnt_width_lp'(1);
          end
        end
        ACTIVE: state_r <= ACTIVE;
        default: state_r <= INIT;
      endcase
    end
  end

  // send only happens with credits_r != 0, so the subtraction cannot wrap
  assign credit_sum = sum_width_lp'(credits_r)
                    - sum_width_lp'(send)
                    + (token_i ? sum_width_lp'(token_decimation_p) : '0);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      credits_r  <= credit_width_lp'(credits_p);
      overflow_r <= 1'b0;
    end else if (credit_sum > sum_width_lp'(credits_p)) begin
      credits_r  <= credit_width_lp'(credits_p);
      overflow_r <= 1'b1;
    end else begin
      credits_r  <= credit_width_lp'(credit_sum);
    end
  end

  // driven from registered state only so the PHY path never sees input glitches
  always_comb begin
    phy_data_o = '0;
    if (eligible)
      phy_data_o = {1'b1, head[payload_width_p-1:half_lp], 1'b1, head[half_lp-1:0]};
  end

  assign ready_o           = ready_r;
  assign link_active_o     = (state_r == ACTIVE);
  assign credit_overflow_o = overflow_r;
  assign credits_o         = credits_r;

endmodule

// File: tb/tb_bsg_link_oddr_upstream.sv
module tb_bsg_link_oddr_upstream;

  localparam int CW = 16;
  localparam int P  = 2*(CW-1);

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic [P-1:0]  data_i = '0;
  logic          v_i = 1'b0;
  logic          ready_o;
  logic [2*CW-1:0] phy_data_o;
  logic          phy_ready_i = 1'b0;
  logic          token_i = 1'b0;
  logic          link_active_o;
  logic          credit_overflow_o;
  logic [4:0]    credits_o;

  int checks = 0;
  int errors = 0;

  logic [2*CW-1:0] cap_q [$];
  logic [P-1:0]    words [20];
  int              widx;
  logic            pr_phase;

  bsg_link_oddr_upstream #(
    .channel_width_p(CW),
    .credits_p(16),
    .token_decimation_p(4),
    .init_idle_words_p(8)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .data_i(data_i),
    .v_i(v_i),
    .ready_o(ready_o),
    .phy_data_o(phy_data_o),
    .phy_ready_i(phy_ready_i),
    .token_i(token_i),
    .link_active_o(link_active_o),
    .credit_overflow_o(credit_overflow_o),
    .credits_o(credits_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [2*CW-1:0] frame(input logic [P-1:0] d);
    return {1'b1, d[P-1:P/2], 1'b1, d[P/2-1:0]};
  endfunction

  // One clock: drive inputs, note what the PHY will capture, advance to edge+1.
  task automatic cycle(input logic v, input logic [P-1:0] d, input logic pr, input logic tk);
    v_i = v; data_i = d; phy_ready_i = pr; token_i = tk;
    #1;
    if (pr && phy_data_o[CW-1]) cap_q.push_back(phy_data_o);
    @(posedge clk_i); #1;
  endtask

  task automatic bring_up();
    v_i = 1'b0; token_i = 1'b0; phy_ready_i = 1'b0;
    #2 reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, (i % 2) == 0, 1'b0);
    pr_phase = 1'b1;
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    #2 reset_i = 1'b1;
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
    checks++; if (credits_o !== 5'd16) begin errors++; $display("FAIL reset_credits: got %0d expected 16", credits_o); end
    checks++; if (credit_overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", credit_overflow_o); end
    checks++; if (link_active_o !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", link_active_o); end
    checks++; if (phy_data_o !== 32'h0) begin errors++; $display("FAIL reset_phy_data: got %h expected 0", phy_data_o); end
    @(posedge clk_i); #1;
    reset_i = 1'b0;
  endtask

  // Also covers framing: 30'h2AAA_5555 has bit 15 clear, so its upper half is
  // 15'h5554 -> 32'hD554_D555; 30'h2AAA_D555 splits into two 15'h5555 halves.
  task automatic test_preamble();
    int r;
    r = 0;
    cap_q.delete();
    for (int i = 0; i < 20; i++) begin
      logic pr;
      pr = (i % 2) == 0;
      if (pr) begin
        r++;
        if (r <= 8) begin
          checks++; if (phy_data_o !== 32'h0) begin errors++; $display("FAIL preamble_idle_%0d: got %h expected 0", r, phy_data_o); end
        end
        if (r == 8) begin
          checks++; if (link_active_o !== 1'b0) begin errors++; $display("FAIL preamble_early_active: got %b expected 0", link_active_o); end
        end
        if (r == 9) begin
          checks++; if (phy_data_o !== 32'hD554_D555) begin errors++; $display("FAIL framing_word0: got %h expected d554d555", phy_data_o); end
        end
        if (r == 10) begin
          checks++; if (phy_data_o !== 32'hD555_D555) begin errors++; $display("FAIL framing_word1: got %h expected d555d555", phy_data_o); end
        end
      end
      cycle(i < 2, (i == 0) ? 30'h2AAA_5555 : 30'h2AAA_D555, pr, 1'b0);
      if (i == 1) begin
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL init_fifo_full_ready: got %b expected 0", ready_o); end
      end
      if (pr && r == 8) begin
        checks++; if (link_active_o !== 1'b1) begin errors++; $display("FAIL preamble_active: got %b expected 1", link_active_o); end
      end
    end
    checks++; if (credits_o !== 5'd14) begin errors++; $display("FAIL preamble_credits: got %0d expected 14", credits_o); end
    checks++; if (cap_q.size() != 2) begin errors++; $display("FAIL preamble_capture_count: got %0d expected 2", cap_q.size()); end
  endtask

  task automatic stream(input int n_cycles, input logic first_token);
    for (int i = 0; i < n_cycles; i++) begin
      logic v, acc;
      v = widx < 20;
      acc = v && ready_o;
      cycle(v, v ? words[widx] : '0, pr_phase, first_token && (i == 0));
      if (acc) widx++;
      pr_phase = ~pr_phase;
    end
  endtask

  task automatic test_credit_exhaustion();
    bring_up();
    cap_q.delete();
    for (int k = 0; k < 20; k++) words[k] = P'((32'h0100_0001 * (k + 1)) ^ 32'h1555_AAAA);
    widx = 0;
    stream(80, 1'b0);
    checks++; if (cap_q.size() != 16) begin errors++; $display("FAIL exhaust_count: got %0d expected 16", cap_q.size()); end
    checks++; if (credits_o !== 5'd0) begin errors++; $display("FAIL exhaust_credits: got %0d expected 0", credits_o); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL exhaust_ready: got %b expected 0", ready_o); end
    checks++; if (phy_data_o !== 32'h0) begin errors++; $display("FAIL exhaust_idle: got %h expected 0", phy_data_o); end
    checks++; if (widx != 18) begin errors++; $display("FAIL exhaust_accepted: got %0d expected 18", widx); end
    for (int k = 0; k < 16 && k < cap_q.size(); k++) begin
      checks++; if (cap_q[k] !== frame(words[k])) begin errors++; $display("FAIL exhaust_word_%0d: got %h expected %h", k, cap_q[k], frame(words[k])); end
    end
    stream(40, 1'b1);
    checks++; if (cap_q.size() != 20) begin errors++; $display("FAIL token_count: got %0d expected 20", cap_q.size()); end
    checks++; if (credits_o !== 5'd0) begin errors++; $display("FAIL token_credits: got %0d expected 0", credits_o); end
    for (int k = 16; k < 20 && k < cap_q.size(); k++) begin
      checks++; if (cap_q[k] !== frame(words[k])) begin errors++; $display("FAIL token_word_%0d: got %h expected %h", k, cap_q[k], frame(words[k])); end
    end
  endtask

  task automatic test_simultaneous();
    int n;
    cycle(1'b0, '0, 1'b0, 1'b1);
    checks++; if (credits_o !== 5'd4) begin errors++; $display("FAIL sim_token_credits: got %0d expected 4", credits_o); end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 30'h0ABC_0000 + P'(k), 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    checks++; if (credits_o !== 5'd1) begin errors++; $display("FAIL sim_credits_one: got %0d expected 1", credits_o); end
    cycle(1'b1, 30'h0123_4567, 1'b0, 1'b0);
    checks++; if (phy_data_o !== 32'h8246_C567) begin errors++; $display("FAIL sim_framing: got %h expected 8246c567", phy_data_o); end
    n = cap_q.size();
    cycle(1'b0, '0, 1'b1, 1'b1);
    checks++; if (credits_o !== 5'd4) begin errors++; $display("FAIL sim_send_token_credits: got %0d expected 4", credits_o); end
    checks++; if (credit_overflow_o !== 1'b0) begin errors++; $display("FAIL sim_overflow: got %b expected 0", credit_overflow_o); end
    checks++; if (cap_q.size() != n + 1 || cap_q[cap_q.size()-1] !== 32'h8246_C567) begin
      errors++; $display("FAIL sim_captured: got %0d words, last %h expected one more ending 8246c567", cap_q.size(), cap_q[cap_q.size()-1]);
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    checks++; if (credits_o !== 5'd12) begin errors++; $display("FAIL sim_credits_twelve: got %0d expected 12", credits_o); end
    cycle(1'b0, '0, 1'b0, 1'b1);
    checks++; if (credits_o !== 5'd16) begin errors++; $display("FAIL exact_limit_credits: got %0d expected 16", credits_o); end
    checks++; if (credit_overflow_o !== 1'b0) begin errors++; $display("FAIL exact_limit_overflow: got %b expected 0", credit_overflow_o); end
  endtask

  task automatic test_overflow();
    cycle(1'b1, 30'h1111_2222, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    checks++; if (credits_o !== 5'd15) begin errors++; $display("FAIL ovf_pre_credits: got %0d expected 15", credits_o); end
    cycle(1'b0, '0, 1'b0, 1'b1);
    checks++; if (credits_o !== 5'd16) begin errors++; $display("FAIL ovf_saturate: got %0d expected 16", credits_o); end
    checks++; if (credit_overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", credit_overflow_o); end
    cycle(1'b1, 30'h0333_4444, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    checks++; if (credits_o !== 5'd15) begin errors++; $display("FAIL ovf_post_credits: got %0d expected 15", credits_o); end
    checks++; if (credit_overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", credit_overflow_o); end
  endtask

  task automatic test_reset_midstream();
    int n;
    cycle(1'b1, 30'h3C3C_0F0F, 1'b0, 1'b0);
    cycle(1'b1, 30'h0F0F_3C3C, 1'b0, 1'b0);
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL mid_full_ready: got %b expected 0", ready_o); end
    n = cap_q.size();
    #2 reset_i = 1'b1;
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b expected 1", ready_o); end
    checks++; if (credits_o !== 5'd16) begin errors++; $display("FAIL mid_reset_credits: got %0d expected 16", credits_o); end
    checks++; if (phy_data_o !== 32'h0) begin errors++; $display("FAIL mid_reset_phy_data: got %h expected 0", phy_data_o); end
    checks++; if (credit_overflow_o !== 1'b0) begin errors++; $display("FAIL mid_reset_overflow: got %b expected 0", credit_overflow_o); end
    checks++; if (link_active_o !== 1'b0) begin errors++; $display("FAIL mid_reset_active: got %b expected 0", link_active_o); end
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    for (int i = 0; i < 14; i++) cycle(1'b0, '0, (i % 2) == 0, 1'b0);
    checks++; if (link_active_o !== 1'b0) begin errors++; $display("FAIL mid_preamble_early: got %b expected 0", link_active_o); end
    for (int i = 14; i < 30; i++) cycle(1'b0, '0, (i % 2) == 0, 1'b0);
    checks++; if (link_active_o !== 1'b1) begin errors++; $display("FAIL mid_preamble_active: got %b expected 1", link_active_o); end
    checks++; if (cap_q.size() != n) begin errors++; $display("FAIL mid_discarded_emitted: got %0d words expected %0d", cap_q.size(), n); end
  endtask

  initial begin
    test_reset();
    test_preamble();
    test_credit_exhaustion();
    test_simultaneous();
    test_overflow();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
